// File: rtl/pack_pkg.sv
// Shared types and defaults for the bit-map read-side packer.
package pack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_SOP,
    ST_SEQ,
    ST_PAY,
    ST_CSUM,
    ST_GAP
  } state_t;

  localparam logic [7:0] HDR_BYTE_DEF  = 8'hA5;
  localparam int         CAP_WORDS_DEF = 8192;

  // avail must hold CAP_WORDS itself; byte counters must hold 4*1024-1
  localparam int AVAIL_W   = 14;
  localparam int BYTE_CNT_W = 12;

endpackage

// File: rtl/bm_pack_ctrl_if.sv
// Buffer read port plus packer output stream, bundled for the controller.
interface bm_pack_ctrl_if;

  logic       bm_vld;
  logic       bm_req;
  logic [7:0] bm_q;
  logic [7:0] pk_data;
  logic       pk_vld;
  logic       pk_sop;
  logic       pk_eop;
  logic       pk_rdy;

  // master: the controller side
  modport master (
    input  bm_vld, bm_q, pk_rdy,
    output bm_req, pk_data, pk_vld, pk_sop, pk_eop
  );

  // slave: buffer and downstream packer side
  modport slave (
    output bm_vld, bm_q, pk_rdy,
    input  bm_req, pk_data, pk_vld, pk_sop, pk_eop
  );

endinterface

// File: rtl/bm_fill_cnt.sv
// Words-available counter for the bit-map buffer, with saturation at
// capacity and a sticky overflow flag.
module bm_fill_cnt
  import pack_pkg::*;
#(
  parameter int BURST_WORDS = 16,
  parameter int CAP_WORDS   = CAP_WORDS_DEF
) (
  input  logic               clk_sys,
  input  logic               rst,
  input  logic               inc,
  input  logic               take,
  output logic [AVAIL_W-1:0] avail,
  output logic               ovf_err
);

  localparam logic [AVAIL_W-1:0] ONE   = AVAIL_W'(1);
  localparam logic [AVAIL_W-1:0] BURST = AVAIL_W'(BURST_WORDS);
  localparam logic [AVAIL_W-1:0] CAP   = AVAIL_W'(CAP_WORDS);

  // A take is only issued when avail >= BURST, so the subtraction never
  // underflows; a lone increment at capacity clamps and flags overflow.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      avail   <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (inc && take) begin
        avail <= avail + ONE - BURST;
      end else if (take) begin
        avail <= avail - BURST;
      end else if (inc) begin
        if (avail >= CAP) begin
          avail   <= CAP;
          ovf_err <= 1'b1;
        end else begin
          avail <= avail + ONE;
        end
      end
    end
  end

endmodule

// File: rtl/bm_pack_ctrl.sv
// Read-side sequencer: requests one burst from the bit-map buffer when
// enough words are available and wraps the returned bytes as
// header, sequence, payload, checksum.
module bm_pack_ctrl
  import pack_pkg::*;
#(
  parameter int         BURST_WORDS = 16,
  parameter logic [7:0] HDR_BYTE    = HDR_BYTE_DEF,
  parameter int         CAP_WORDS   = CAP_WORDS_DEF
) (
  input  logic                  clk_sys,
  input  logic                  rst,
  input  logic                  en,
  bm_pack_ctrl_if.master        bus,
  output logic                  ovf_err,
  output logic [15:0]           frame_cnt
);

  localparam logic [BYTE_CNT_W-1:0] LAST_IDX = BYTE_CNT_W'(4 * BURST_WORDS - 1);
  localparam logic [BYTE_CNT_W-1:0] CNT_ONE  = BYTE_CNT_W'(1);
  localparam logic [AVAIL_W-1:0]    BURST    = AVAIL_W'(BURST_WORDS);

  state_t                state;
  logic [AVAIL_W-1:0]    avail;
  logic                  start;
  logic [BYTE_CNT_W-1:0] req_cnt;
  logic [BYTE_CNT_W-1:0] pay_cnt;
  logic [7:0]            seq;
  logic [7:0]            csum;

  assign start = (state == ST_IDLE) && en && bus.pk_rdy && (avail >= BURST);

  bm_fill_cnt #(
    .BURST_WORDS (BURST_WORDS),
    .CAP_WORDS   (CAP_WORDS)
  ) u_fill (
    .clk_sys (clk_sys),
    .rst     (rst),
    .inc     (bus.bm_vld),
    .take    (start),
    .avail   (avail),
    .ovf_err (ovf_err)
  );

  // Frame sequencer: the request down-counter runs independently of the
  // state so bm_req covers ARM through the early PAY cycles, while the
  // state register sequences the registered output bytes.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      bus.bm_req  <= 1'b0;
      req_cnt     <= '0;
      pay_cnt     <= '0;
      seq         <= '0;
      csum        <= '0;
      bus.pk_data <= '0;
      bus.pk_vld  <= 1'b0;
      bus.pk_sop  <= 1'b0;
      bus.pk_eop  <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      if (bus.bm_req) begin
        if (req_cnt == '0) begin
          bus.bm_req <= 1'b0;
        end else begin
          req_cnt <= req_cnt - CNT_ONE;
        end
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_ARM;
            bus.bm_req <= 1'b1;
            req_cnt    <= LAST_IDX;
            csum       <= '0;
          end
        end
        ST_ARM: begin
          state       <= ST_SOP;
          bus.pk_data <= HDR_BYTE;
          bus.pk_vld  <= 1'b1;
          bus.pk_sop  <= 1'b1;
        end
        ST_SOP: begin
          state       <= ST_SEQ;
          bus.pk_data <= seq;
          bus.pk_sop  <= 1'b0;
          csum        <= csum + seq;
        end
        ST_SEQ: begin
          state       <= ST_PAY;
          bus.pk_data <= bus.bm_q;
          csum        <= csum + bus.bm_q;
          pay_cnt     <= LAST_IDX;
        end
        ST_PAY: begin
          if (pay_cnt == '0) begin
            state       <= ST_CSUM;
            bus.pk_data <= csum;
            bus.pk_eop  <= 1'b1;
          end else begin
            bus.pk_data <= bus.bm_q;
            csum        <= csum + bus.bm_q;
            pay_cnt     <= pay_cnt - CNT_ONE;
          end
        end
        ST_CSUM: begin
          state       <= ST_GAP;
          bus.pk_data <= '0;
          bus.pk_vld  <= 1'b0;
          bus.pk_eop  <= 1'b0;
          seq         <= seq + 8'd1;
          frame_cnt   <= frame_cnt + 16'd1;
        end
        ST_GAP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bm_pack_ctrl.sv
// Self-checking bench for bm_pack_ctrl: a two-cycle-latency buffer model,
// a byte scoreboard fed by each scenario, and per-scenario checks.
module tb_bm_pack_ctrl;
  import pack_pkg::*;

  localparam int N   = 4;
  localparam int CAP = 8192;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } exp_t;

  logic        clk_sys = 1'b0;
  logic        rst     = 1'b1;
  logic        en      = 1'b0;
  logic        ovf_err;
  logic [15:0] frame_cnt;

  bm_pack_ctrl_if bus ();

  bm_pack_ctrl #(.BURST_WORDS(N)) dut (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .en        (en),
    .bus       (bus.master),
    .ovf_err   (ovf_err),
    .frame_cnt (frame_cnt)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         req_cycles = 0;
  int         first_req_cyc = -1;
  int         eop_cyc = -1;
  int         sop_cycs[$];
  logic       prev_req = 1'b0;
  exp_t       exp_q[$];
  exp_t       exp_item;
  logic [7:0] pat_xor = 8'h00;
  int         req_idx = 0;
  logic [7:0] pipe1 = 8'h00;

  always #5 clk_sys = ~clk_sys;

  // Cycle index, advanced on every active edge
  always @(posedge clk_sys) cyc++;

  // Buffer model: the byte for request cycle k appears on bm_q in cycle k+2
  always @(posedge clk_sys) begin
    if (bus.bm_req) begin
      pipe1   <= 8'(req_idx + 1) ^ pat_xor;
      req_idx <= req_idx + 1;
    end else begin
      pipe1   <= 8'h00;
      req_idx <= 0;
    end
    bus.bm_q <= pipe1;
  end

  // Output monitor: compares every valid byte against the scoreboard
  always @(negedge clk_sys) begin
    if (!rst) begin
      if (bus.bm_req) begin
        req_cycles++;
        if (!prev_req) first_req_cyc = cyc;
      end
      prev_req = bus.bm_req;
      if (bus.pk_vld) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_byte got data=%h sop=%b eop=%b want no byte",
                   bus.pk_data, bus.pk_sop, bus.pk_eop);
        end else begin
          exp_item = exp_q.pop_front();
          if ({bus.pk_sop, bus.pk_eop, bus.pk_data} !== exp_item) begin
            errors++;
            $display("[TB] FAIL stream_byte cyc=%0d got data=%h sop=%b eop=%b want data=%h sop=%b eop=%b",
                     cyc, bus.pk_data, bus.pk_sop, bus.pk_eop,
                     exp_item.data, exp_item.sop, exp_item.eop);
          end
        end
      end
      if (bus.pk_sop) sop_cycs.push_back(cyc);
      if (bus.pk_eop) eop_cyc = cyc;
    end else begin
      prev_req = 1'b0;
    end
  end

  function automatic exp_t mk(input logic s, input logic e, input logic [7:0] d);
    exp_t r;
    r.sop  = s;
    r.eop  = e;
    r.data = d;
    return r;
  endfunction

  // Queue the full expected frame for a given sequence byte and pattern
  task automatic push_frame(input logic [7:0] s);
    logic [7:0] sum;
    logic [7:0] b;
    sum = s;
    exp_q.push_back(mk(1'b1, 1'b0, 8'hA5));
    exp_q.push_back(mk(1'b0, 1'b0, s));
    for (int i = 0; i < 4 * N; i++) begin
      b   = 8'(i + 1) ^ pat_xor;
      sum = sum + b;
      exp_q.push_back(mk(1'b0, 1'b0, b));
    end
    exp_q.push_back(mk(1'b0, 1'b1, sum));
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic pulse_vld(input int n);
    repeat (n) begin
      bus.bm_vld = 1'b1;
      tick();
    end
    bus.bm_vld = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int k;
    k = 0;
    while (frame_cnt != 16'(target) && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (frame_cnt !== 16'(target)) begin
      errors++;
      $display("[TB] FAIL frame_wait got frame_cnt=%0d want %0d within %0d cycles",
               frame_cnt, target, budget);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    tick(2);
    checks++;
    if ({bus.bm_req, bus.pk_vld, bus.pk_sop, bus.pk_eop, bus.pk_data, ovf_err, frame_cnt} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got req=%b vld=%b sop=%b eop=%b data=%h ovf=%b fc=%0d want all 0",
               bus.bm_req, bus.pk_vld, bus.pk_sop, bus.pk_eop, bus.pk_data, ovf_err, frame_cnt);
    end
    check_int("reset_avail", int'(dut.u_fill.avail), 0);
    checks++;
    if (dut.state !== ST_IDLE) begin
      errors++;
      $display("[TB] FAIL reset_state got %0d want %0d", dut.state, ST_IDLE);
    end
    rst = 1'b0;
    tick(2);
    check_int("idle_req", int'(bus.bm_req), 0);
  endtask

  task automatic test_single_frame();
    $display("[TB] test_single_frame");
    en = 1'b1;
    bus.pk_rdy = 1'b1;
    pat_xor = 8'h00;
    req_cycles = 0;
    sop_cycs.delete();
    push_frame(8'h00);
    pulse_vld(N);
    wait_frames(1, 100);
    tick(2);
    check_int("single_req_cycles", req_cycles, 4 * N);
    check_int("single_avail", int'(dut.u_fill.avail), 0);
    check_int("single_queue_left", exp_q.size(), 0);
    check_int("single_sop_count", sop_cycs.size(), 1);
    if (sop_cycs.size() > 0) begin
      check_int("single_sop_after_req", sop_cycs[0], first_req_cyc + 1);
      check_int("single_eop_cycle", eop_cyc, sop_cycs[0] + 2 + 4 * N);
    end
  endtask

  task automatic test_threshold();
    int cv;
    $display("[TB] test_threshold");
    req_cycles = 0;
    pulse_vld(N - 1);
    tick(10);
    check_int("thr_no_req", req_cycles, 0);
    check_int("thr_avail", int'(dut.u_fill.avail), N - 1);
    check_int("thr_state_idle", int'(dut.state), int'(ST_IDLE));
    pat_xor = 8'h30;
    push_frame(8'h01);
    cv = cyc;
    pulse_vld(1);
    wait_frames(2, 100);
    checks++;
    if (first_req_cyc < cv + 1 || first_req_cyc > cv + 2) begin
      errors++;
      $display("[TB] FAIL thr_arm_latency got req at cyc %0d want cyc %0d..%0d",
               first_req_cyc, cv + 1, cv + 2);
    end
    tick(2);
    check_int("thr_queue_left", exp_q.size(), 0);
  endtask

  task automatic test_ready_gate();
    $display("[TB] test_ready_gate");
    bus.pk_rdy = 1'b0;
    req_cycles = 0;
    pulse_vld(2 * N);
    tick(10);
    check_int("rdy_no_req", req_cycles, 0);
    check_int("rdy_avail", int'(dut.u_fill.avail), 2 * N);
    pat_xor = 8'h5A;
    push_frame(8'h02);
    push_frame(8'h03);
    sop_cycs.delete();
    bus.pk_rdy = 1'b1;
    wait_frames(4, 200);
    tick(4);
    check_int("rdy_avail_end", int'(dut.u_fill.avail), 0);
    check_int("rdy_req_cycles", req_cycles, 8 * N);
    check_int("rdy_sop_count", sop_cycs.size(), 2);
    if (sop_cycs.size() == 2)
      check_int("rdy_frame_period", sop_cycs[1] - sop_cycs[0], 4 * N + 6);
    check_int("rdy_queue_left", exp_q.size(), 0);
  endtask

  task automatic test_same_cycle();
    $display("[TB] test_same_cycle");
    bus.pk_rdy = 1'b0;
    pulse_vld(N);
    tick(2);
    check_int("same_avail_before", int'(dut.u_fill.avail), N);
    pat_xor = 8'h00;
    push_frame(8'h04);
    bus.bm_vld = 1'b1;
    bus.pk_rdy = 1'b1;
    tick();
    bus.bm_vld = 1'b0;
    check_int("same_avail_after", int'(dut.u_fill.avail), 1);
    check_int("same_req_high", int'(bus.bm_req), 1);
    wait_frames(5, 100);
    tick(2);
    check_int("same_queue_left", exp_q.size(), 0);
  endtask

  task automatic test_overflow();
    int k;
    $display("[TB] test_overflow");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en = 1'b0;
    bus.pk_rdy = 1'b1;
    tick();
    pulse_vld(CAP);
    check_int("ovf_at_cap_flag", int'(ovf_err), 0);
    check_int("ovf_at_cap_avail", int'(dut.u_fill.avail), CAP);
    pulse_vld(1);
    check_int("ovf_flag", int'(ovf_err), 1);
    check_int("ovf_avail_clamp", int'(dut.u_fill.avail), CAP);
    pat_xor = 8'hC3;
    push_frame(8'h00);
    en = 1'b1;
    k = 0;
    while (!bus.bm_req && k < 10) begin
      tick();
      k++;
    end
    en = 1'b0;
    wait_frames(1, 100);
    tick(10);
    check_int("ovf_one_frame_only", int'(frame_cnt), 1);
    check_int("ovf_sticky", int'(ovf_err), 1);
    check_int("ovf_avail_after", int'(dut.u_fill.avail), CAP - N);
    check_int("ovf_queue_left", exp_q.size(), 0);
    rst = 1'b1;
    #2;
    check_int("ovf_rst_clear", int'(ovf_err), 0);
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int k;
    $display("[TB] test_reset_mid");
    en = 1'b1;
    bus.pk_rdy = 1'b1;
    pat_xor = 8'h00;
    sop_cycs.delete();
    push_frame(8'h00);
    pulse_vld(N);
    k = 0;
    while (sop_cycs.size() == 0 && k < 20) begin
      tick();
      k++;
    end
    check_int("mid_sop_seen", sop_cycs.size(), 1);
    if (sop_cycs.size() > 0) begin
      k = 0;
      while (cyc < sop_cycs[0] + 6 && k < 20) begin
        tick();
        k++;
      end
      #2;
      check_int("mid_pre_req", int'(bus.bm_req), 1);
      check_int("mid_pre_vld", int'(bus.pk_vld), 1);
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.bm_req, bus.pk_vld, bus.pk_sop, bus.pk_eop, bus.pk_data, frame_cnt} !== '0) begin
        errors++;
        $display("[TB] FAIL mid_reset_outputs got req=%b vld=%b sop=%b eop=%b data=%h fc=%0d want all 0",
                 bus.bm_req, bus.pk_vld, bus.pk_sop, bus.pk_eop, bus.pk_data, frame_cnt);
      end
    end
    rst = 1'b1;
    exp_q.delete();
    tick(2);
    rst = 1'b0;
    tick();
    pat_xor = 8'h77;
    push_frame(8'h00);
    pulse_vld(N);
    wait_frames(1, 100);
    tick(2);
    check_int("mid_queue_left", exp_q.size(), 0);
  endtask

  initial begin
    bus.bm_vld = 1'b0;
    bus.pk_rdy = 1'b0;
    test_reset();
    test_single_frame();
    test_threshold();
    test_ready_gate();
    test_same_cycle();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bm_pack_ctrl.md
# bm_pack_ctrl

Read-side sequencer for the 32 KiB bit-map byte buffer. It counts 32-bit words written into the buffer and, once a full burst is available and the downstream packer is ready, drives the buffer's read-request line for one burst. It wraps the returned bytes in a framed byte stream: header, sequence byte, payload, checksum. It sits between the buffer's read port and the uplink packet mux in the pack_top hierarchy.

## Interface
- BURST_WORDS, 16: words per frame. Payload is 4*BURST_WORDS bytes. Legal range 1..1024.
- HDR_BYTE, 8'hA5: start-of-frame marker byte.
- CAP_WORDS, 8192: buffer capacity in words, used for overflow detection.

Ports:
- clk_sys  in  1  system clock; every register is in this domain.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  frame start enable. Low blocks new frames; a frame in progress always completes.
- bm_vld  in  1  one-cycle pulse per 32-bit word written into the buffer.
- bm_req  out  1  buffer read request. Registered.
- bm_q  in  8  buffer read byte. The byte for request cycle k is valid 2 cycles after that cycle.
- pk_data  out  8  framed output byte. Registered.
- pk_vld  out  1  pk_data valid.
- pk_sop  out  1  first byte of frame (HDR_BYTE).
- pk_eop  out  1  last byte of frame (checksum).
- pk_rdy  in  1  downstream can accept a whole frame. Sampled only in IDLE.
- ovf_err  out  1  sticky flag: word count exceeded CAP_WORDS.
- frame_cnt  out  16  frames completed, wraps at 16'hFFFF.

## Operation
- avail counter (14 bit):
  - +1 on bm_vld.
  - -BURST_WORDS on frame start (ARM entry).
  - When both happen in the same cycle, net change is +1-BURST_WORDS.
  - An increment that would exceed CAP_WORDS sets ovf_err and clamps avail at CAP_WORDS.
  - ovf_err clears only on rst.
- FSM states: IDLE, ARM, SOP, SEQ, PAY, CSUM, GAP.
  - IDLE->ARM when en & pk_rdy & (avail >= BURST_WORDS); otherwise stay in IDLE.
  - ARM->SOP->SEQ->PAY unconditionally, one cycle each.
  - PAY lasts exactly 4*BURST_WORDS cycles, then ->CSUM.
  - CSUM->GAP after one cycle. GAP->IDLE after one cycle.
- bm_req is high for exactly 4*BURST_WORDS consecutive cycles, starting in the ARM cycle. It is driven by a down-counter loaded on ARM entry.
- Output bytes:
  - SOP: HDR_BYTE, with pk_sop=1.
  - SEQ: seq.
  - PAY: registered bm_q.
  - CSUM: csum, with pk_eop=1.
  - pk_vld=1 in SOP, SEQ, PAY and CSUM only.
- seq (8 bit): starts at 0 and increments on leaving CSUM, wrapping 255->0.
- csum: 8-bit modulo-256 sum of the seq byte and all payload bytes. Cleared in ARM.
- frame_cnt increments on leaving CSUM.
- en or pk_rdy dropping mid-frame has no effect on the frame in progress.

## Timing
- Let S be the SOP cycle.
  - bm_req: high S-1 .. S+4N-2, where N = BURST_WORDS.
  - Payload bytes: S+2 .. S+1+4N.
  - CSUM: S+2+4N.
  - Earliest next ARM: S+5+4N (after GAP and one IDLE cycle).
- Frame length: 4N+3 bytes, back-to-back with no bubbles. Minimum frame period: 4N+6 cycles.
- Reset values: all outputs 0; FSM in IDLE; avail, seq and csum 0.
- Reset mid-frame clears everything immediately (asynchronously), including bm_req. Downstream discards the partial frame, which has no eop.
- A bm_vld arriving during a frame is counted normally.

## Structure
- Shared package pack_pkg holds:
  - state enum (7 states, 3 bit);
  - HDR_BYTE default;
  - CAP_WORDS default.
- One sub-module, bm_fill_cnt: the avail counter with saturation and overflow. All other logic is flat in bm_pack_ctrl.

## Test plan
- N=4; 4 bm_vld pulses with pk_rdy=en=1; buffer model returns 8'h01..8'h10 -> bm_req high exactly 16 cycles; stream is A5,00,01..10,88 (csum=0x88); sop on A5, eop on 88; frame_cnt=1; avail=0.
- N=4; only 3 words written -> no bm_req, FSM stays in IDLE. Fourth bm_vld arrives -> ARM on the next cycle.
- pk_rdy=0 with avail=8 -> no frame. pk_rdy rises -> two frames with seq 0 and 1, separated by GAP+IDLE; avail ends at 0.
- bm_vld asserted in the same cycle as ARM entry, with avail=4 and N=4 -> avail=1 after the cycle.
- CAP_WORDS+1 bm_vld pulses with en=0 -> ovf_err=1, avail=CAP_WORDS; ovf_err stays 1 through later frames until rst.
- rst asserted in PAY cycle 5 -> bm_req, pk_vld and all outputs 0 immediately. After release, seq=0 and the next frame starts from IDLE.
